// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder step per RUN cycle, LSB first.
// Result and carry are registered and held from the done pulse until the next accept.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_c;
    logic [CntW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_busy;
    logic              r_done;
    logic              r_start_prev;

    logic              w_s;
    logic              w_c;
    logic              w_last;
    logic              w_accept;

    assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
    assign w_c    = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    assign w_last = (r_cnt == CntW'(WIDTH - 1));

    // A request held across the result cycle chains into the next operation; a request
    // that first appears in the DONE cycle is dropped, never remembered.
    assign w_accept = start & ((r_state == StIdle) | ((r_state == StDone) & r_start_prev));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= 1'b0;
            r_cnt        <= '0;
            r_sum        <= '0;
            r_cout       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_start_prev <= 1'b0;
        end else begin
            r_start_prev <= start;
            r_done       <= 1'b0;
            unique case (r_state)
                StIdle, StDone: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_c     <= cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                StRun: begin
                    r_sum <= {w_s, r_sum[WIDTH-1:1]};
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_c;
                    r_cnt <= r_cnt + CntW'(1);
                    if (w_last) begin
                        r_cout  <= w_c;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: a WIDTH=8 instance for the directed scenarios
// and a WIDTH=2 instance for the exhaustive sweep; expected {cout,sum} queued at accept.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;

    int n_vec;
    int n_err;

    logic [8:0] exp_q8[$];
    logic [2:0] exp_q2[$];

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start8),
        .a    (a8),
        .b    (b8),
        .cin  (cin8),
        .busy (busy8),
        .done (done8),
        .sum  (sum8),
        .cout (cout8)
    );

    serial_add_ctrl #(.WIDTH(2)) u_dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start2),
        .a    (a2),
        .b    (b2),
        .cin  (cin2),
        .busy (busy2),
        .done (done2),
        .sum  (sum2),
        .cout (cout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents an operation before the next rising edge; expectation queued only if wanted.
    task automatic drive8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input bit push);
        @(negedge clk);
        a8 = ta;
        b8 = tb;
        cin8 = tc;
        start8 = 1'b1;
        if (push) exp_q8.push_back(9'(ta) + 9'(tb) + 9'(tc));
    endtask

    // Counts falling edges after the accept edge until done is seen; to=1 if never seen.
    task automatic wait_done8(output int cyc, output bit to);
        cyc = 0;
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            cyc++;
            if (done8) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_w8: got busy=%b done=%b cout=%b sum=%h, want all 0",
                     busy8, done8, cout8, sum8);
        end
        n_vec++;
        if ({busy2, done2, cout2, sum2} !== 5'd0) begin
            n_err++;
            $display("FAIL reset_w2: got busy=%b done=%b cout=%b sum=%h, want all 0",
                     busy2, done2, cout2, sum2);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [8:0] e;
        bit seen;
        drive8(8'h5A, 8'h3C, 1'b0, 1'b1);
        @(posedge clk);
        seen = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            n_vec++;
            if (busy8 !== 1'b1) begin
                n_err++;
                $display("FAIL basic_busy cyc%0d: got %b want 1", k, busy8);
            end
            n_vec++;
            if (done8 !== (k == 9)) begin
                n_err++;
                $display("FAIL basic_done cyc%0d: got %b want %b", k, done8, (k == 9));
            end
            if (done8) seen = 1'b1;
        end
        if (seen) begin
            e = exp_q8.pop_front();
            n_vec++;
            if ({cout8, sum8} !== e) begin
                n_err++;
                $display("FAIL basic_result: got cout=%b sum=%h want cout=%b sum=%h",
                         cout8, sum8, e[8], e[7:0]);
            end
        end
        @(negedge clk);
        n_vec++;
        if ({busy8, done8, cout8, sum8} !== {2'b00, 9'h096}) begin
            n_err++;
            $display("FAIL basic_hold: got busy=%b done=%b cout=%b sum=%h want 0 0 0 96",
                     busy8, done8, cout8, sum8);
        end
    endtask

    task automatic test_carry;
        logic [7:0] va[4] = '{8'hFF, 8'hFF, 8'h80, 8'h00};
        logic [7:0] vb[4] = '{8'h01, 8'hFF, 8'h80, 8'h00};
        logic       vc[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [8:0] e;
        int cyc;
        bit to;
        for (int i = 0; i < 4; i++) begin
            drive8(va[i], vb[i], vc[i], 1'b1);
            @(posedge clk);
            wait_done8(cyc, to);
            n_vec++;
            if (to || cyc != 9) begin
                n_err++;
                $display("FAIL carry_latency %0d: got %0d cycles (timeout=%b) want 9", i, cyc, to);
            end
            if (!to) begin
                e = exp_q8.pop_front();
                n_vec++;
                if ({cout8, sum8} !== e) begin
                    n_err++;
                    $display("FAIL carry_result %0d: got cout=%b sum=%h want cout=%b sum=%h",
                             i, cout8, sum8, e[8], e[7:0]);
                end
            end else exp_q8.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [8:0] e;
        start8 = 1'b0;
        for (int k = 0; k <= 36; k++) begin
            @(negedge clk);
            n_vec++;
            if (done8 !== (k > 0 && k % 9 == 0)) begin
                n_err++;
                $display("FAIL b2b_done k=%0d: got %b want %b", k, done8, (k > 0 && k % 9 == 0));
            end
            if (done8) begin
                n_vec++;
                if (exp_q8.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_result k=%0d: got unexpected done, want none", k);
                end else begin
                    e = exp_q8.pop_front();
                    if ({cout8, sum8} !== e) begin
                        n_err++;
                        $display("FAIL b2b_result k=%0d: got cout=%b sum=%h want cout=%b sum=%h",
                                 k, cout8, sum8, e[8], e[7:0]);
                    end
                end
            end
            if (k < 36) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                cin8 = 1'($urandom);
                start8 = 1'b1;
                if (k % 9 == 0) exp_q8.push_back(9'(a8) + 9'(b8) + 9'(cin8));
            end else begin
                start8 = 1'b0;
            end
        end
        @(negedge clk);
        n_vec++;
        if (busy8 !== 1'b0 || exp_q8.size() != 0) begin
            n_err++;
            $display("FAIL b2b_end: got busy=%b pending=%0d want busy=0 pending=0",
                     busy8, exp_q8.size());
        end
        exp_q8.delete();
    endtask

    task automatic test_done_start;
        logic [8:0] e;
        int cyc;
        bit to;
        drive8(8'h12, 8'h34, 1'b1, 1'b1);
        @(posedge clk);
        wait_done8(cyc, to);
        start8 = 1'b1;
        if (!to) begin
            e = exp_q8.pop_front();
            n_vec++;
            if ({cout8, sum8} !== e) begin
                n_err++;
                $display("FAIL donestart_result: got cout=%b sum=%h want cout=%b sum=%h",
                         cout8, sum8, e[8], e[7:0]);
            end
        end else exp_q8.delete();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            n_vec++;
            if (busy8 !== 1'b0 || done8 !== 1'b0) begin
                n_err++;
                $display("FAIL donestart_ignored k=%0d: got busy=%b done=%b want 0 0",
                         k, busy8, done8);
            end
        end
    endtask

    task automatic test_reset_abort;
        logic [8:0] e;
        int cyc;
        bit to;
        drive8(8'hAA, 8'h77, 1'b1, 1'b0);
        @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            start8 = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            n_err++;
            $display("FAIL abort_clear: got busy=%b done=%b cout=%b sum=%h want all 0",
                     busy8, done8, cout8, sum8);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                n_err++;
                $display("FAIL abort_quiet k=%0d: got busy=%b done=%b want 0 0", k, busy8, done8);
            end
        end
        rst_n = 1'b1;
        drive8(8'h10, 8'h20, 1'b1, 1'b1);
        @(posedge clk);
        wait_done8(cyc, to);
        n_vec++;
        if (to) begin
            n_err++;
            $display("FAIL abort_after: got timeout, want done");
            exp_q8.delete();
        end else begin
            e = exp_q8.pop_front();
            if ({cout8, sum8} !== e) begin
                n_err++;
                $display("FAIL abort_after: got cout=%b sum=%h want cout=%b sum=%h",
                         cout8, sum8, e[8], e[7:0]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_w2_exhaustive;
        logic [2:0] e;
        int cyc;
        bit to;
        for (int v = 0; v < 32; v++) begin
            @(negedge clk);
            a2 = 2'(v >> 3);
            b2 = 2'(v >> 1);
            cin2 = 1'(v);
            start2 = 1'b1;
            exp_q2.push_back(3'(a2) + 3'(b2) + 3'(cin2));
            @(posedge clk);
            cyc = 0;
            to = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                start2 = 1'b0;
                cyc++;
                if (done2) begin
                    to = 1'b0;
                    break;
                end
            end
            e = exp_q2.pop_front();
            n_vec++;
            if (to || cyc != 3 || {cout2, sum2} !== e) begin
                n_err++;
                $display("FAIL w2 a=%0d b=%0d cin=%0d: got cyc=%0d cout=%b sum=%0d want cyc=3 cout=%b sum=%0d",
                         a2, b2, cin2, cyc, cout2, sum2, e[2], e[1:0]);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_done_start();
        test_reset_abort();
        test_w2_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
